// File: rtl/iommu_wsi_gateway.sv
// iommu_wsi_gateway: platform-side receiver for the IOMMU wired-signaled interrupt vector,
// with per-wire edge/level capture, fixed-priority claim handshake and completion by ID.
module iommu_wsi_gateway #(
    parameter int                   NUM_WIRES  = 16,
    parameter logic [NUM_WIRES-1:0] LEVEL_MASK = '0,
    parameter int                   DROP_CNT_W = 8,
    localparam int                  IDW        = $clog2(NUM_WIRES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_WIRES-1:0]  wsi_wires_i,
    input  logic [NUM_WIRES-1:0]  enable_i,
    output logic                  claim_valid_o,
    input  logic                  claim_ready_i,
    output logic [IDW-1:0]        claim_id_o,
    input  logic                  complete_valid_i,
    input  logic [IDW-1:0]        complete_id_i,
    output logic                  complete_err_o,
    output logic                  irq_o,
    output logic [NUM_WIRES-1:0]  pending_o,
    output logic [NUM_WIRES-1:0]  inflight_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);
    typedef enum logic {IDLE, OFFER} state_t;
    state_t                state_q, state_d;
    logic [NUM_WIRES-1:0]  wire_q, pending_q, inflight_q;
    logic [NUM_WIRES-1:0]  pending_d, inflight_d, inflight_clr;
    logic [NUM_WIRES-1:0]  rise, edge_set, lvl_set, drops, eligible;
    logic [NUM_WIRES-1:0]  claim_mask, comp_mask;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_d;
    logic [IDW-1:0]        id_q, sel_id;
    logic                  irq_q, err_q, handshake;

    assign eligible     = pending_q & enable_i & ~inflight_q;
    assign handshake    = (state_q == OFFER) & claim_ready_i;
    assign claim_mask   = handshake ? NUM_WIRES'(1) << id_q : '0;
    // Out-of-range ids shift to zero, so they fall into the error path naturally
    assign comp_mask    = complete_valid_i ? (NUM_WIRES'(1) << complete_id_i) & inflight_q : '0;
    assign inflight_clr = inflight_q & ~comp_mask;
    assign inflight_d   = inflight_clr | claim_mask;
    assign rise         = wsi_wires_i & ~wire_q;
    assign edge_set     = rise & ~LEVEL_MASK;
    // A level wire may re-pend in the same cycle its completion lands
    assign lvl_set      = wsi_wires_i & LEVEL_MASK & ~pending_q & ~inflight_clr;
    assign pending_d    = (pending_q & ~claim_mask) | edge_set | lvl_set;
    // A rise coinciding with the claim of its own wire re-pends, so it is not lost
    assign drops        = edge_set & pending_q & ~claim_mask;

    always_comb begin
        sel_id = '0;
        for (int i = NUM_WIRES - 1; i >= 0; i--)
            if (eligible[i]) sel_id = IDW'(i);
    end

    always_comb begin
        drop_d = drop_cnt_q;
        for (int i = 0; i < NUM_WIRES; i++)
            if (drops[i] && drop_d != '1) drop_d = drop_d + 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (|eligible ? OFFER : IDLE) : (claim_ready_i ? IDLE : OFFER);
    end

    always_comb begin
        claim_valid_o = state_q == OFFER;
        claim_id_o    = claim_valid_o ? id_q : '0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wire_q     <= '0;
            pending_q  <= '0;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            id_q       <= '0;
            irq_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wire_q     <= wsi_wires_i;
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_d;
            if (state_q == IDLE && |eligible) id_q <= sel_id;
            irq_q      <= |eligible | (state_q == OFFER);
            err_q      <= complete_valid_i & ~|comp_mask;
        end
    end

    assign pending_o      = pending_q;
    assign inflight_o     = inflight_q;
    assign drop_cnt_o     = drop_cnt_q;
    assign irq_o          = irq_q;
    assign complete_err_o = err_q;
endmodule

// File: tb/tb_iommu_wsi_gateway.sv
// tb_iommu_wsi_gateway: directed stimulus with a claim-ID scoreboard drained by a handshake monitor.
module tb_iommu_wsi_gateway;
    logic        clk = 1'b0, rst;
    logic [15:0] wires, en;
    logic        claim_valid, claim_ready, complete_valid, complete_err, irq;
    logic [3:0]  claim_id, complete_id;
    logic [15:0] pending, inflight;
    logic [1:0]  drop_cnt;
    int          n_chk = 0, n_fail = 0;
    int          exp_q[$];

    iommu_wsi_gateway #(.NUM_WIRES(16), .LEVEL_MASK(16'h0080), .DROP_CNT_W(2)) dut (
        .clk_i(clk), .rst_i(rst), .wsi_wires_i(wires), .enable_i(en),
        .claim_valid_o(claim_valid), .claim_ready_i(claim_ready), .claim_id_o(claim_id),
        .complete_valid_i(complete_valid), .complete_id_i(complete_id),
        .complete_err_o(complete_err), .irq_o(irq), .pending_o(pending),
        .inflight_o(inflight), .drop_cnt_o(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_offer(input string name);
        for (int i = 0; i < 10 && !claim_valid; i++) tick;
        check(name, claim_valid, 1);
    endtask

    task automatic handshake;
        claim_ready = 1'b1;
        tick;
        claim_ready = 1'b0;
    endtask

    task automatic complete(input logic [3:0] id);
        complete_valid = 1'b1;
        complete_id = id;
        tick;
        complete_valid = 1'b0;
    endtask

    task automatic pulse(input int w);
        wires[w] = 1'b1;
        tick;
        wires[w] = 1'b0;
        tick;
    endtask

    always @(negedge clk) begin
        if (!rst && claim_valid && claim_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL claim_unexpected: got id %0d expected no claim", claim_id);
            end else check("claim_id", claim_id, exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        wires = '0; en = '1; claim_ready = 0; complete_valid = 0; complete_id = 0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", claim_valid, 0);
        check("rst_id", claim_id, 0);
        check("rst_pending", pending, 0);
        check("rst_inflight", inflight, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_err", complete_err, 0);
        check("rst_irq", irq, 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("idle_valid", claim_valid, 0);
        end

        // edge wire 3: offer two cycles after the rise
        wires[3] = 1'b1;
        exp_q.push_back(3);
        tick;
        wires[3] = 1'b0;
        check("w3_n1_valid", claim_valid, 0);
        tick;
        check("w3_n2_valid", claim_valid, 1);
        check("w3_n2_id", claim_id, 3);
        check("w3_irq", irq, 1);
        handshake;
        check("w3_inflight", inflight, 16'h0008);
        check("w3_pending", pending, 0);
        check("w3_valid_off", claim_valid, 0);
        complete(3);
        check("w3_done_inflight", inflight, 0);
        check("w3_done_err", complete_err, 0);

        // wires 5 and 2 together: lower index first, next offer two cycles after handshake
        wires[2] = 1'b1; wires[5] = 1'b1;
        exp_q.push_back(2); exp_q.push_back(5);
        tick;
        wires = '0;
        tick;
        check("p_first_id", claim_id, 2);
        handshake;
        check("p_gap_valid", claim_valid, 0);
        tick;
        check("p_second_valid", claim_valid, 1);
        check("p_second_id", claim_id, 5);
        handshake;
        check("p_inflight", inflight, 16'h0024);
        complete(2);
        complete(5);
        check("p_done", inflight, 0);

        // rise on the claimed wire in the handshake cycle: set wins
        wires[3] = 1'b1;
        exp_q.push_back(3);
        tick;
        wires[3] = 1'b0;
        tick;
        claim_ready = 1'b1;
        wires[3] = 1'b1;
        tick;
        claim_ready = 1'b0;
        wires[3] = 1'b0;
        check("sw_pending", pending[3], 1);
        check("sw_inflight", inflight[3], 1);
        check("sw_drop", drop_cnt, 0);
        tick;
        check("sw_no_offer", claim_valid, 0);
        exp_q.push_back(3);
        complete(3);
        wait_offer("sw_reoffer");
        handshake;
        complete(3);

        // level wire 7 held: one claim, re-pends on completion
        wires[7] = 1'b1;
        exp_q.push_back(7);
        tick;
        tick;
        check("lv_valid", claim_valid, 1);
        handshake;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("lv_hold_valid", claim_valid, 0);
        end
        check("lv_hold_pending", pending[7], 0);
        exp_q.push_back(7);
        complete(7);
        check("lv_repend", pending[7], 1);
        check("lv_inflight", inflight[7], 0);
        wait_offer("lv_reoffer");
        handshake;
        wires[7] = 1'b0;
        complete(7);
        tick;
        check("lv_quiet_pending", pending, 0);
        check("lv_quiet_inflight", inflight, 0);

        // completion of a wire not in flight
        complete(4);
        check("err_pulse", complete_err, 1);
        check("err_pending", pending, 0);
        check("err_inflight", inflight, 0);
        tick;
        check("err_clear", complete_err, 0);

        // dropped edges on disabled wire 1, then saturation of the 2-bit counter
        en[1] = 1'b0;
        for (int i = 0; i < 3; i++) pulse(1);
        check("drop_pending", pending[1], 1);
        check("drop_cnt2", drop_cnt, 2);
        check("drop_no_offer", claim_valid, 0);
        for (int i = 0; i < 3; i++) pulse(1);
        check("drop_sat", drop_cnt, 3);
        en[1] = 1'b1;
        exp_q.push_back(1);
        wait_offer("drop_offer");
        handshake;
        complete(1);

        // async reset during an offer
        pulse(0);
        wait_offer("rst_pre_offer");
        #1 rst = 1'b1;
        #1;
        check("arst_valid", claim_valid, 0);
        check("arst_pending", pending, 0);
        check("arst_drop", drop_cnt, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick;
        check("arst_after_valid", claim_valid, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
